// File: rtl/fir_dec_accum.sv
// fir_dec_accum -- decimating accumulate-and-dump stage behind the FIR low-pass.
//
// After enable it drops the first SETTLE valid samples, because the FIR pipeline is
// still filling. It then sums blocks of 2^D valid samples. Each block sum is rounded
// half-up, arithmetic-shifted right by D+OUT_SHIFT and clipped to OUT_WIDTH signed bits.
// One registered, valid-strobed sample is emitted per block.
//
// Handshake: din is consumed on every rising clk edge where din_valid=1. Gaps only
// stretch a block. dout_valid is a one-cycle strobe and there is no backpressure.
// dout and sat hold their values between strobes.
//
// Optional feature, macro DEC_SAT_CNT_EN:
//   defined   -> sat_cnt counts clipped strobes, sticks at 16'hFFFF, and is cleared
//                by rst and by cfg_load
//   undefined -> sat_cnt is tied to 0
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   run enable; low returns to IDLE and drops any partial block
//   din        in   [IN_WIDTH-1:0]  signed FIR output sample
//   din_valid  in   din qualifier
//   dec_log2   in   [3:0] decimation exponent D (values above MAX_DEC_LOG2 are clamped)
//   cfg_load   in   one-cycle pulse: latch dec_log2 and restart the current block
//   dout       out  [OUT_WIDTH-1:0] signed decimated sample
//   dout_valid out  one-cycle strobe when dout updates
//   sat        out  set when the current dout was clipped
//   sat_cnt    out  [15:0] saturation event count
module fir_dec_accum #(
  parameter int IN_WIDTH     = 30,
  parameter int OUT_WIDTH    = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int MAX_DEC_LOG2 = 10,
  parameter int SETTLE       = 19,
  parameter int OUT_SHIFT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 din_valid,
  input  logic [3:0]           dec_log2,
  input  logic                 cfg_load,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 sat,
  output logic [15:0]          sat_cnt
);

  localparam int CW = MAX_DEC_LOG2 + 1;                   // block sample counter
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;  // settle counter
  localparam int XW = ACC_WIDTH + 1;                      // headroom for the rounding add

  localparam logic signed [XW-1:0] OUT_MAX =
    {{(XW + 1 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [XW-1:0] OUT_MIN =
    {{(XW + 1 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             d_lat;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          settle_cnt;
  logic signed [ACC_WIDTH-1:0] acc;

  logic [3:0]             d_new;
  logic signed [ACC_WIDTH-1:0] din_ext;
  logic [CW-1:0]          block_last;
  logic                   dump_fire;
  logic [5:0]             shamt;
  logic signed [XW-1:0]   sum_x;
  logic signed [XW-1:0]   rnd_x;
  logic signed [XW-1:0]   pre_x;
  logic signed [XW-1:0]   r_x;
  logic [OUT_WIDTH-1:0]   clip_val;
  logic                   clip;

  always_comb begin
    d_new      = (dec_log2 > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2;
    din_ext    = {{(ACC_WIDTH - IN_WIDTH){din[IN_WIDTH-1]}}, din};
    block_last = (CW'(1) << d_lat) - CW'(1);
    // The block closes on the 2^D-th valid sample. A simultaneous cfg_load discards it.
    dump_fire  = en && (state == S_ACCUM) && !cfg_load && din_valid && (cnt == block_last);

    // The dump sample is folded in here, so the accumulator can restart
    // on the same edge without losing a sample.
    sum_x = {acc[ACC_WIDTH-1], acc} + {din_ext[ACC_WIDTH-1], din_ext};
    shamt = 6'(d_lat) + 6'(OUT_SHIFT);
    rnd_x = (shamt == 6'd0) ? '0 : (XW'(1) << (shamt - 6'd1));
    pre_x = sum_x + rnd_x;
    r_x   = pre_x >>> shamt;

    clip     = 1'b0;
    clip_val = r_x[OUT_WIDTH-1:0];
    if (r_x > OUT_MAX) begin
      clip     = 1'b1;
      clip_val = OUT_MAX[OUT_WIDTH-1:0];
    end else if (r_x < OUT_MIN) begin
      clip     = 1'b1;
      clip_val = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      d_lat      <= 4'd0;
      cnt        <= '0;
      settle_cnt <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (!en) begin
        state      <= S_IDLE;
        cnt        <= '0;
        settle_cnt <= '0;
        acc        <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            d_lat      <= d_new;
            cnt        <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            state      <= (SETTLE == 0) ? S_ACCUM : S_SETTLE;
          end
          S_SETTLE: begin
            // A new D here does not restart the fill count, because the FIR is still priming.
            if (cfg_load) d_lat <= d_new;
            if (din_valid) begin
              if (settle_cnt == SW'(SETTLE - 1)) begin
                settle_cnt <= '0;
                state      <= S_ACCUM;
              end else begin
                settle_cnt <= settle_cnt + SW'(1);
              end
            end
          end
          S_ACCUM: begin
            if (cfg_load) begin
              // Restart the block under the new D. The filter stays primed, so there is no re-settle.
              d_lat <= d_new;
              acc   <= '0;
              cnt   <= '0;
            end else if (dump_fire) begin
              acc        <= '0;
              cnt        <= '0;
              dout       <= clip_val;
              sat        <= clip;
              dout_valid <= 1'b1;
            end else if (din_valid) begin
              acc <= acc + din_ext;
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DEC_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      sat_cnt <= 16'h0000;
    end else if (dump_fire && clip && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'h0001;
    end
  end
`else
  assign sat_cnt = 16'h0000;
`endif

endmodule
